// File: rtl/parity_types_pkg.sv
// Parity selection shared by the UART receive path (uart_frame_rx, parity_check).
package parity_types_pkg;

  typedef enum logic [2:0] {
    EVEN  = 3'd0,
    ODD   = 3'd1,
    MARK  = 3'd2,
    SPACE = 3'd3,
    NONE  = 3'd4
  } parity_t;

endpackage

// File: rtl/uart_frame_rx.sv
// UART frame receiver: oversampled start/data/parity/stop deserializer with valid/ready output.
// Optional UART_RX_GLITCH_FILTER_EN: 2-of-3 majority vote around each bit centre.
module uart_frame_rx #(
  parameter int unsigned BITWIDTH   = 8,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      sampleTick,
  input  logic                      rxIn,
  input  parity_types_pkg::parity_t parityType,
  output logic [BITWIDTH:0]         frameOut,
  output logic                      frameValid,
  input  logic                      frameReady,
  output logic                      framingError,
  output logic                      overrunError,
  output logic                      busy
);

  localparam int unsigned TICK_W    = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
  localparam int unsigned BIT_W     = $clog2(BITWIDTH);
  localparam int unsigned MID_TICK  = OVERSAMPLE / 2 - 1;
  localparam int unsigned LAST_TICK = OVERSAMPLE - 1;
`ifdef UART_RX_GLITCH_FILTER_EN
  localparam int unsigned DEC_TICK  = MID_TICK + 1;
`else
  localparam int unsigned DEC_TICK  = MID_TICK;
`endif

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic                      r_sync1;
  logic                      r_sync2;
  logic                      r_sync_prev;
  logic [2:0]                r_state;
  logic [TICK_W-1:0]         r_tick_cnt;
  logic [BIT_W-1:0]          r_bit_cnt;
  logic [BITWIDTH-1:0]       r_data;
  logic                      r_par;
  parity_types_pkg::parity_t r_par_lat;
  logic                      r_stop_bad;

  logic [2:0]                w_state_nxt;
  logic [TICK_W-1:0]         w_tick_nxt;
  logic [BIT_W-1:0]          w_bit_nxt;
  logic [BITWIDTH-1:0]       w_data_nxt;
  logic                      w_par_nxt;
  parity_types_pkg::parity_t w_lat_nxt;
  logic                      w_stop_bad_nxt;
  logic                      w_done;
  logic                      w_frame_err;
  logic [TICK_W-1:0]         w_target;
  logic                      w_sample;
  logic                      w_bit;

  // Bit value presented at the decision tick
`ifdef UART_RX_GLITCH_FILTER_EN
  logic [1:0] r_hist;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hist <= 2'b11;
    end else if (sampleTick) begin
      r_hist <= {r_hist[0], r_sync2};
    end
  end

  assign w_bit = (r_hist[1] & r_hist[0]) | (r_hist[1] & r_sync2) | (r_hist[0] & r_sync2);
`else
  assign w_bit = r_sync2;
`endif

  // Start bit decides at the bit centre; later bits one full bit period after the previous decision
  assign w_target = (r_state == S_START) ? TICK_W'(DEC_TICK) : TICK_W'(LAST_TICK);
  assign w_sample = sampleTick && (r_tick_cnt == w_target);

  always_comb begin
    w_state_nxt    = r_state;
    w_tick_nxt     = r_tick_cnt;
    w_bit_nxt      = r_bit_cnt;
    w_data_nxt     = r_data;
    w_par_nxt      = r_par;
    w_lat_nxt      = r_par_lat;
    w_stop_bad_nxt = r_stop_bad;
    w_done         = 1'b0;
    w_frame_err    = 1'b0;

    if ((r_state != S_IDLE) && sampleTick) begin
      w_tick_nxt = w_sample ? '0 : r_tick_cnt + 1'b1;
    end

    case (r_state)
      S_IDLE: begin
        if (r_sync_prev && !r_sync2) begin
          w_lat_nxt      = parityType;
          w_tick_nxt     = '0;
          w_bit_nxt      = '0;
          w_par_nxt      = 1'b0;
          w_stop_bad_nxt = 1'b0;
          w_state_nxt    = S_START;
        end
      end
      S_START: begin
        if (w_sample) begin
          w_state_nxt = w_bit ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (w_sample) begin
          w_data_nxt = {w_bit, r_data[BITWIDTH-1:1]};
          if (r_bit_cnt == BIT_W'(BITWIDTH - 1)) begin
            w_bit_nxt   = '0;
            w_state_nxt = (r_par_lat == parity_types_pkg::NONE) ? S_STOP : S_PARITY;
          end else begin
            w_bit_nxt = r_bit_cnt + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (w_sample) begin
          w_par_nxt   = w_bit;
          w_state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (w_sample) begin
          w_stop_bad_nxt = r_stop_bad | ~w_bit;
          if (r_bit_cnt == BIT_W'(STOP_BITS - 1)) begin
            w_bit_nxt   = '0;
            w_state_nxt = S_IDLE;
            w_frame_err = w_stop_bad_nxt;
            w_done      = ~w_stop_bad_nxt;
          end else begin
            w_bit_nxt = r_bit_cnt + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1      <= 1'b1;
      r_sync2      <= 1'b1;
      r_sync_prev  <= 1'b1;
      r_state      <= S_IDLE;
      r_tick_cnt   <= '0;
      r_bit_cnt    <= '0;
      r_data       <= '0;
      r_par        <= 1'b0;
      r_par_lat    <= parity_types_pkg::NONE;
      r_stop_bad   <= 1'b0;
      frameOut     <= '0;
      frameValid   <= 1'b0;
      framingError <= 1'b0;
      overrunError <= 1'b0;
      busy         <= 1'b0;
    end else begin
      r_sync1      <= rxIn;
      r_sync2      <= r_sync1;
      r_sync_prev  <= r_sync2;
      r_state      <= w_state_nxt;
      r_tick_cnt   <= w_tick_nxt;
      r_bit_cnt    <= w_bit_nxt;
      r_data       <= w_data_nxt;
      r_par        <= w_par_nxt;
      r_par_lat    <= w_lat_nxt;
      r_stop_bad   <= w_stop_bad_nxt;
      framingError <= w_frame_err;
      overrunError <= w_done & frameValid & ~frameReady;
      busy         <= (w_state_nxt != S_IDLE);
      // A completing frame may replace the held one only when that one is leaving this cycle
      if (w_done && (!frameValid || frameReady)) begin
        frameOut   <= {r_data, r_par};
        frameValid <= 1'b1;
      end else if (frameValid && frameReady) begin
        frameValid <= 1'b0;
      end
    end
  end

endmodule
